// File: rtl/hack_cpu_hs.sv
// rtl/hack_cpu_hs.sv - multi-cycle Hack CPU with request/ack memories; HACK_CPU_HS_HALT_EN enables self-jump halt
module hack_cpu_hs #(
    parameter int DW = 16,
    parameter int AW = 15
) (
    input  logic          clk,
    input  logic          reset_n,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [DW-1:0] imem_rdata,
    output logic          dmem_re,
    output logic          dmem_we,
    output logic [AW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    input  logic          dmem_ack,
    input  logic [DW-1:0] dmem_rdata,
    output logic [AW-1:0] pc,
    output logic          halted
);

    typedef enum logic [2:0] {FETCH, DECODE, LOAD, EXEC, STORE, COMMIT, HALT} state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] ir, a_reg, d_reg, m_reg, alu_q;
    logic [AW-1:0] pc_q, pc_inc;
    logic          zr_q, ng_q, run;

    logic is_c, sel_m, zx, nx, zy, ny, f, no, d1, d2, d3, j1, j2, j3;
    assign is_c  = ir[DW-1];
    assign sel_m = ir[12];
    assign zx    = ir[11];
    assign nx    = ir[10];
    assign zy    = ir[9];
    assign ny    = ir[8];
    assign f     = ir[7];
    assign no    = ir[6];
    assign d1    = ir[5];
    assign d2    = ir[4];
    assign d3    = ir[3];
    assign j1    = ir[2];
    assign j2    = ir[1];
    assign j3    = ir[0];

    logic [DW-1:0] x0, x1, y0, y1, alu_out;
    always_comb begin
        x0      = zx ? '0 : d_reg;
        x1      = nx ? ~x0 : x0;
        y0      = zy ? '0 : (sel_m ? m_reg : a_reg);
        y1      = ny ? ~y0 : y0;
        alu_out = f ? (x1 + y1) : (x1 & y1);
        if (no) begin
            alu_out = ~alu_out;
        end
    end

    logic take_jump, self_halt;
    assign take_jump = (j1 & ng_q) | (j2 & zr_q) | (j3 & ~ng_q & ~zr_q);
    assign pc_inc    = pc_q + AW'(1);

`ifdef HACK_CPU_HS_HALT_EN
    assign self_halt = j1 & j2 & j3 & (a_reg[AW-1:0] == pc_q);
    assign halted    = (state == HALT);
`else
    assign self_halt = 1'b0;
    assign halted    = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // run holds off the first fetch until the first edge after reset release
    always_comb begin
        state_nxt = state;
        case (state)
            FETCH:   if (run && imem_ack) state_nxt = DECODE;
            DECODE:  state_nxt = !is_c ? FETCH : (sel_m ? LOAD : EXEC);
            LOAD:    if (dmem_ack) state_nxt = EXEC;
            EXEC:    state_nxt = d3 ? STORE : COMMIT;
            STORE:   if (dmem_ack) state_nxt = COMMIT;
            COMMIT:  state_nxt = self_halt ? HALT : FETCH;
            HALT:    state_nxt = HALT;
            default: state_nxt = FETCH;
        endcase
    end

    always_comb begin
        imem_req = 1'b0;
        dmem_re  = 1'b0;
        dmem_we  = 1'b0;
        case (state)
            FETCH:   imem_req = run;
            LOAD:    dmem_re  = 1'b1;
            STORE:   dmem_we  = 1'b1;
            default: ;
        endcase
    end

    assign imem_addr  = imem_req ? pc_q : '0;
    assign dmem_addr  = (dmem_re | dmem_we) ? a_reg[AW-1:0] : '0;
    assign dmem_wdata = dmem_we ? alu_q : '0;
    assign pc         = pc_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run   <= 1'b0;
            pc_q  <= '0;
            a_reg <= '0;
            d_reg <= '0;
            ir    <= '0;
            m_reg <= '0;
            alu_q <= '0;
            zr_q  <= 1'b0;
            ng_q  <= 1'b0;
        end else begin
            run <= 1'b1;
            case (state)
                FETCH: begin
                    if (run && imem_ack) ir <= imem_rdata;
                end
                DECODE: begin
                    if (!is_c) begin
                        a_reg <= {1'b0, ir[DW-2:0]};
                        pc_q  <= pc_inc;
                    end
                end
                LOAD: begin
                    if (dmem_ack) m_reg <= dmem_rdata;
                end
                EXEC: begin
                    alu_q <= alu_out;
                    zr_q  <= (alu_out == '0);
                    ng_q  <= alu_out[DW-1];
                end
                COMMIT: begin
                    // jump target reads A before the d1 write lands
                    if (d1) a_reg <= alu_q;
                    if (d2) d_reg <= alu_q;
                    pc_q <= take_jump ? a_reg[AW-1:0] : pc_inc;
                end
                default: ;
            endcase
        end
    end

endmodule
